seven_segment_reader: RTL and testbench

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_segment_pkg.sv | 17 +
 rtl/seven_segment_pattern_decode.sv | 29 ++
 rtl/seven_segment_reader.sv | 151 +++++++++++++++
 tb/tb_seven_segment_reader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment patterns, special codes and FSM states for the seven-segment reader.
package seven_segment_pkg;
    localparam logic [6:0] PAT_0     = 7'b0000001;
    localparam logic [6:0] PAT_1     = 7'b1001111;
    localparam logic [6:0] PAT_2     = 7'b0010010;
    localparam logic [6:0] PAT_3     = 7'b0000110;
    localparam logic [6:0] PAT_4     = 7'b1001100;
    localparam logic [6:0] PAT_5     = 7'b0100100;
    localparam logic [6:0] PAT_6     = 7'b0100000;
    localparam logic [6:0] PAT_7     = 7'b0001111;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0000100;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;
    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
endpackage

// File: rtl/seven_segment_pattern_decode.sv
// seven_segment_pattern_decode: active-low segment pattern to digit code, flagging unknown patterns.
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] code_o,
    output logic       err_o
);
    always_comb begin
        err_o = 1'b0;
        case (pat_i)
            PAT_0:     code_o = 4'd0;
            PAT_1:     code_o = 4'd1;
            PAT_2:     code_o = 4'd2;
            PAT_3:     code_o = 4'd3;
            PAT_4:     code_o = 4'd4;
            PAT_5:     code_o = 4'd5;
            PAT_6:     code_o = 4'd6;
            PAT_7:     code_o = 4'd7;
            PAT_8:     code_o = 4'd8;
            PAT_9:     code_o = 4'd9;
            PAT_BLANK: code_o = CODE_BLANK;
            default: begin
                code_o = CODE_ERR;
                err_o  = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: debounces a multiplexed seven-segment scan into decoded frames with valid/ready.
// Define SEVEN_SEGMENT_DP_EN to also capture the decimal point (seg_dp_n in, dp_o out).
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
`ifdef SEVEN_SEGMENT_DP_EN
    input  logic                    seg_dp_n,
    output logic [NUM_DIGITS-1:0]   dp_o,
`endif
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   err_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overflow_o
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef SEVEN_SEGMENT_DP_EN
    localparam int TW = IW + 8;
`else
    localparam int TW = IW + 7;
`endif

    logic [IW-1:0]           idx;
    logic [TW-1:0]           tag, tag_q;
    logic [7:0]              cnt_q;
    state_t                  state_q;
    logic                    legal, same, acc, full, free, dec_err;
    logic [3:0]              dec_code;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d, stg_err_q, stg_err_d, err_q, err_d;
    logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, val_q, val_d;
    logic                    valid_q, valid_d, ovf_q, ovf_d;
`ifdef SEVEN_SEGMENT_DP_EN
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, dp_q, dp_d;
`endif

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!dig_sel_n[i]) idx = IW'(i);
    end

    assign legal = $countones(~dig_sel_n) == 1;
`ifdef SEVEN_SEGMENT_DP_EN
    assign tag = {idx, seg_in, seg_dp_n};
`else
    assign tag = {idx, seg_in};
`endif
    assign same = tag == tag_q;
    // A new tag restarts the count at 1, so it accepts immediately only when one sample suffices
    assign acc  = legal && ((state_q == IDLE || !same) ? STABLE_CYCLES == 1
                            : state_q == SETTLE && cnt_q == 8'(STABLE_CYCLES - 1));

    seven_segment_pattern_decode u_decode (
        .pat_i  (seg_in),
        .code_o (dec_code),
        .err_o  (dec_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else if (!legal) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (state_q == IDLE || !same) begin
            tag_q   <= tag;
            cnt_q   <= 8'd1;
            state_q <= STABLE_CYCLES == 1 ? LOCKED : SETTLE;
        end else if (state_q == SETTLE) begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= acc ? LOCKED : SETTLE;
        end
    end

    assign full = &mask_q;
    assign free = !valid_q || ready_i;

    always_comb begin
        stg_val_d = stg_val_q;
        stg_err_d = stg_err_q;
        mask_d    = full ? '0 : mask_q;
        val_d     = val_q;
        err_d     = err_q;
`ifdef SEVEN_SEGMENT_DP_EN
        stg_dp_d  = stg_dp_q;
        dp_d      = dp_q;
`endif
        if (acc) begin
            stg_val_d[{idx, 2'b00} +: 4] = dec_code;
            stg_err_d[idx]               = dec_err;
            mask_d[idx]                  = 1'b1;
`ifdef SEVEN_SEGMENT_DP_EN
            stg_dp_d[idx]                = ~seg_dp_n;
`endif
        end
        if (full && free) begin
            val_d = stg_val_q;
            err_d = stg_err_q;
`ifdef SEVEN_SEGMENT_DP_EN
            dp_d  = stg_dp_q;
`endif
        end
        valid_d = (full && free) || (valid_q && !ready_i);
        ovf_d   = ovf_q || (full && !free);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q    <= '0;
            stg_val_q <= '1;
            stg_err_q <= '0;
            val_q     <= '1;
            err_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef SEVEN_SEGMENT_DP_EN
            stg_dp_q  <= '0;
            dp_q      <= '0;
`endif
        end else begin
            mask_q    <= mask_d;
            stg_val_q <= stg_val_d;
            stg_err_q <= stg_err_d;
            val_q     <= val_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
`ifdef SEVEN_SEGMENT_DP_EN
            stg_dp_q  <= stg_dp_d;
            dp_q      <= dp_d;
`endif
        end
    end

    assign value_o    = val_q;
    assign err_o      = err_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
`ifdef SEVEN_SEGMENT_DP_EN
    assign dp_o       = dp_q;
`endif
endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed scans of a 4-digit display with hand-computed expected frames.
module tb_seven_segment_reader;
    logic        clk, rst_n, ready_i;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel_n;
    logic [15:0] value_o;
    logic [3:0]  err_o;
    logic        valid_o, overflow_o;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [6:0]  pat [10];
    logic [6:0]  pat_blank, pat_bad;

    seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_sel_n  (dig_sel_n),
        .value_o    (value_o),
        .err_o      (err_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic hold(input int d, input logic [6:0] p, input int n);
        dig_sel_n = ~(4'b0001 << d);
        seg_in    = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dig_sel_n = 4'hF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
        hold(0, p0, 3);
        hold(1, p1, 3);
        hold(2, p2, 3);
        hold(3, p3, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010; pat[3] = 7'b0000110;
        pat[4] = 7'b1001100; pat[5] = 7'b0100100; pat[6] = 7'b0100000; pat[7] = 7'b0001111;
        pat[8] = 7'b0000000; pat[9] = 7'b0000100;
        pat_blank = 7'b1111111;
        pat_bad   = 7'b1010101;
        rst_n = 1'b0; ready_i = 1'b1; dig_sel_n = 4'hF; seg_in = pat_blank;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", value_o, 16'hFFFF);
        check("rst_err", err_o, 4'h0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        rst_n = 1'b1;
        // basic frame 1,2,3,4 with one-cycle latency after the last accept
        frame(pat[1], pat[2], pat[3], pat[4]);
        check("lat_not_early", valid_o, 1'b0);
        idle(1);
        check("f1_valid", valid_o, 1'b1);
        check("f1_value", value_o, 16'h4321);
        check("f1_err", err_o, 4'h0);
        idle(1);
        check("f1_handshake", valid_o, 1'b0);
        check("f1_hold_value", value_o, 16'h4321);
        check("f1_ovf", overflow_o, 1'b0);
        // digit 2 held too briefly: no frame until it is held long enough
        hold(0, pat[5], 3);
        hold(1, pat[6], 3);
        hold(2, pat[7], 2);
        hold(3, pat[8], 3);
        idle(1);
        check("short_no_frame", valid_o, 1'b0);
        hold(2, pat[7], 3);
        idle(1);
        check("short_valid", valid_o, 1'b1);
        check("short_value", value_o, 16'h8765);
        idle(1);
        // blank and invalid patterns
        frame(pat[0], pat_blank, pat[9], pat_bad);
        idle(1);
        check("blank_valid", valid_o, 1'b1);
        check("blank_value", value_o, 16'hE9F0);
        check("blank_err", err_o, 4'b1000);
        idle(1);
        // backpressure: second frame dropped, overflow sticky
        ready_i = 1'b0;
        frame(pat[1], pat[2], pat[3], pat[4]);
        idle(1);
        check("bp_first_valid", valid_o, 1'b1);
        check("bp_first_value", value_o, 16'h4321);
        check("bp_no_ovf_yet", overflow_o, 1'b0);
        frame(pat[5], pat[6], pat[7], pat[8]);
        idle(1);
        check("bp_ovf", overflow_o, 1'b1);
        check("bp_kept_value", value_o, 16'h4321);
        check("bp_kept_err", err_o, 4'h0);
        check("bp_still_valid", valid_o, 1'b1);
        ready_i = 1'b1;
        idle(1);
        check("bp_release", valid_o, 1'b0);
        check("bp_ovf_sticky", overflow_o, 1'b1);
        // illegal select mid-settle restarts the count
        hold(0, pat[9], 3);
        hold(1, pat[8], 3);
        hold(2, pat[7], 3);
        hold(3, pat[6], 2);
        dig_sel_n = 4'b0011;
        @(posedge clk);
        #1;
        hold(3, pat[6], 2);
        idle(1);
        check("illegal_restart", valid_o, 1'b0);
        hold(3, pat[6], 3);
        idle(1);
        check("illegal_valid", valid_o, 1'b1);
        check("illegal_value", value_o, 16'h6789);
        idle(1);
        // reset with three digits staged discards them
        hold(0, pat[1], 3);
        hold(1, pat[2], 3);
        hold(2, pat[3], 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_value", value_o, 16'hFFFF);
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_ovf", overflow_o, 1'b0);
        rst_n = 1'b1;
        hold(3, pat[5], 3);
        idle(1);
        check("mid_rst_discard", valid_o, 1'b0);
        hold(0, pat[1], 3);
        hold(1, pat[2], 3);
        hold(2, pat[3], 3);
        idle(1);
        check("post_rst_valid", valid_o, 1'b1);
        check("post_rst_value", value_o, 16'h5321);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
